// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI transmit path.
//   - Status-nibble constants for the channel-voice and system message groups.
//   - FSM state types for the message sequencer and the byte serialiser.
//   - msg_len():    number of bytes (1..3) a message occupies on the wire,
//                   derived from its status byte.
//   - is_channel(): true for channel-voice status bytes 8x..Ex.
//   - msg_byte():   picks byte 0/1/2 (status/data1/data2) out of a packed message.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PBEND    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} msg_state_t;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PBEND: len = 2'd3;
      PROG, CH_AT:                           len = 2'd2;
      SYS: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd2;   // MTC quarter frame, song select
          4'h2:       len = 2'd3;   // song position pointer
          default:    len = 2'd1;   // sysex start, undefined, realtime
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  function automatic logic is_channel(input logic [7:0] status);
    return (status[7:4] >= NOTE_OFF) && (status[7:4] <= PBEND);
  endfunction

  function automatic logic [7:0] msg_byte(input logic [23:0] msg, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = msg[23:16];
      2'd1:    b = msg[15:8];
      default: b = msg[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/midi_msg_tx_uart.sv
// uart_tx_byte: transmits one 8N1 frame (start 0, 8 data bits LSB first,
// stop 1), each bit exactly BIT_CYCLES clocks long.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset; line returns high immediately
//   start  in   launch a frame with data (honoured only while ready=1)
//   data   in   byte to send, sampled when start & ready
//   ready  out  a new frame may be launched this cycle
//   done   out  final cycle of the stop bit (frame completes at next edge)
//   tx     out  serial line, idle high (registered)
// ready is also high in the last stop-bit cycle so that a following byte can
// be launched with its start bit directly abutting the previous stop bit.
module uart_tx_byte
  import midi_pkg::*;
#(
  parameter int BIT_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= U_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    bit_end    = (cnt_reg == CNT_LAST);

    // The bit counter restarts at every bit boundary.
    if (state_reg != U_IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      U_IDLE: tx_next = 1'b1;
      U_START: begin
        if (bit_end) begin
          state_next = U_DATA;
          bit_next   = 3'd0;
          tx_next    = shift_reg[0];
        end
      end
      U_DATA: begin
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
            state_next = U_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
          end
        end
      end
      U_STOP: begin
        if (bit_end) state_next = U_IDLE;
      end
      default: state_next = U_IDLE;
    endcase

    done  = (state_reg == U_STOP) && bit_end;
    ready = (state_reg == U_IDLE) || done;

    if (start && ready) begin
      state_next = U_START;
      cnt_next   = '0;
      shift_next = data;
      tx_next    = 1'b0;
    end
  end

  assign tx = tx_reg;

endmodule

// File: rtl/midi_msg_tx.sv
// midi_msg_tx: serialises one {status,data1,data2} MIDI message onto MIDI OUT
// as 1..3 back-to-back 8N1 frames at BAUD, with optional running status.
// Ports:
//   CLK        in   system clock
//   nRST       in   asynchronous active-low reset (aborts any frame)
//   MSG        in   [23:16] status, [15:8] data1, [7:0] data2
//   MSG_VALID  in   MSG valid, held until accepted
//   MSG_READY  out  ready to accept (idle and out of reset)
//   MIDI_TX    out  serial line, idle high
//   BUSY       out  from the cycle after acceptance through MSG_DONE
//   MSG_DONE   out  1-cycle pulse after the final stop bit
//   MSG_ERR    out  1-cycle pulse after accepting a message with MSG[23]=0
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 31250,
  parameter bit RUNNING_STATUS = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [23:0] MSG,
  input  logic        MSG_VALID,
  output logic        MSG_READY,
  output logic        MIDI_TX,
  output logic        BUSY,
  output logic        MSG_DONE,
  output logic        MSG_ERR
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;

  msg_state_t  state_reg, state_next;
  logic        run_reg;
  logic [23:0] msg_reg, msg_next;
  logic [1:0]  idx_reg, idx_next;
  logic [1:0]  last_reg, last_next;
  logic [7:0]  rs_reg, rs_next;        // 8'h00 = no running status stored
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        byte_start, byte_ready, byte_done;
  logic [7:0]  byte_data;
  logic [7:0]  status_in;
  logic        accept, skip;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= S_IDLE;
      run_reg   <= 1'b0;
      msg_reg   <= 24'h0;
      idx_reg   <= 2'd0;
      last_reg  <= 2'd0;
      rs_reg    <= 8'h00;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
      msg_reg   <= msg_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      rs_reg    <= rs_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign MSG_READY = run_reg && (state_reg == S_IDLE);

  always_comb begin
    state_next = state_reg;
    msg_next   = msg_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    rs_next    = rs_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    byte_start = 1'b0;
    byte_data  = msg_byte(msg_reg, idx_reg);
    status_in  = MSG[23:16];
    accept     = MSG_VALID && MSG_READY;
    // rs_reg is never 00 while holding a status, so an empty store never matches.
    skip       = RUNNING_STATUS && is_channel(status_in) && (status_in == rs_reg);

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (!status_in[7]) begin
            err_next = 1'b1;              // swallowed, nothing transmitted
          end else begin
            msg_next   = MSG;
            idx_next   = skip ? 2'd1 : 2'd0;
            last_next  = msg_len(status_in) - 2'd1;
            state_next = S_LOAD;
            if (is_channel(status_in)) begin
              rs_next = status_in;
            end else if (status_in[7:4] == SYS && !status_in[3]) begin
              rs_next = 8'h00;            // F0-F7 cancel running status
            end
          end
        end
      end
      S_LOAD: begin
        if (byte_ready) begin
          byte_start = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        // The next byte is picked during the last stop-bit cycle so its start
        // bit abuts the previous stop bit with no idle gap.
        if (byte_done) begin
          if (idx_reg != last_reg) begin
            byte_start = 1'b1;
            byte_data  = msg_byte(msg_reg, idx_reg + 2'd1);
            idx_next   = idx_reg + 2'd1;
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  uart_tx_byte #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart (
    .clk   (CLK),
    .rst_n (nRST),
    .start (byte_start),
    .data  (byte_data),
    .ready (byte_ready),
    .done  (byte_done),
    .tx    (MIDI_TX)
  );

  assign BUSY     = (state_reg != S_IDLE) || done_reg;
  assign MSG_DONE = done_reg;
  assign MSG_ERR  = err_reg;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Testbench for midi_msg_tx. Two instances (running status off / on) share
// MSG and reset; sel chooses which one is driven and observed. Expected line
// bytes go into exp_q when a message is issued; a UART monitor decodes MIDI_TX
// and pops/compares each byte. 16 clocks per bit keeps the run short.
module tb_midi_msg_tx;

  localparam int CLK_FREQ = 500_000;
  localparam int BAUD     = 31250;
  localparam int B        = CLK_FREQ / BAUD;   // 16 clocks per bit
  localparam int BYTE_CYC = 10 * B;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        sel   = 1'b0;
  logic [23:0] msg   = 24'h0;

  logic valid0, ready0, tx0, busy0, done0, err0;
  logic valid1, ready1, tx1, busy1, done1, err1;
  logic ready, line, busy, done, err;

  assign valid0 = valid & ~sel;
  assign valid1 = valid & sel;
  assign ready  = sel ? ready1 : ready0;
  assign line   = sel ? tx1    : tx0;
  assign busy   = sel ? busy1  : busy0;
  assign done   = sel ? done1  : done0;
  assign err    = sel ? err1   : err0;

  always #5 clk = ~clk;

  midi_msg_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .RUNNING_STATUS(1'b0)) dut0 (
    .CLK(clk), .nRST(rst_n), .MSG(msg), .MSG_VALID(valid0), .MSG_READY(ready0),
    .MIDI_TX(tx0), .BUSY(busy0), .MSG_DONE(done0), .MSG_ERR(err0)
  );

  midi_msg_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .RUNNING_STATUS(1'b1)) dut1 (
    .CLK(clk), .nRST(rst_n), .MSG(msg), .MSG_VALID(valid1), .MSG_READY(ready1),
    .MIDI_TX(tx1), .BUSY(busy1), .MSG_DONE(done1), .MSG_ERR(err1)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rst_count = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  always @(negedge rst_n) rst_count++;

  // UART monitor: samples mid-bit on falling clock edges.
  initial begin : monitor
    logic [7:0] got;
    logic       start_bit, stop_bit;
    logic [7:0] want;
    int         epoch;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line === 1'b0) begin
        epoch = rst_count;
        repeat (B / 2) @(negedge clk);
        start_bit = line;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          got[i] = line;
        end
        repeat (B) @(negedge clk);
        stop_bit = line;
        // Frames cut short by a reset are dropped.
        if (epoch == rst_count) begin
          check("mon_start_bit", int'(start_bit), 0);
          check("mon_stop_bit", int'(stop_bit), 1);
          check("mon_byte_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("mon_byte", int'(got), int'(want));
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 4 * BYTE_CYC) begin
      @(negedge clk);
      k++;
    end
    check({name, "_ready"}, int'(ready), 1);
  endtask

  // Called at acceptance edge + #1; returns on the negedge where MSG_DONE is seen.
  task automatic wait_done(input string name, input int n);
    int cyc, first_low;
    cyc = 0;
    first_low = 0;
    while (cyc < n * BYTE_CYC + 20) begin
      @(negedge clk);
      cyc++;
      if (first_low == 0 && line === 1'b0) first_low = cyc;
      if (done === 1'b1) break;
    end
    check({name, "_tx_fall_cycle"}, first_low, 2);
    check({name, "_done_cycle"}, cyc, n * BYTE_CYC + 2);
    check({name, "_busy_at_done"}, int'(busy), 1);
  endtask

  task automatic run_msg(input string name, input logic [23:0] m, input int n,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    int d0, r0;
    if (n > 0) exp_q.push_back(e0);
    if (n > 1) exp_q.push_back(e1);
    if (n > 2) exp_q.push_back(e2);
    wait_ready(name);
    d0 = done_cnt;
    r0 = err_cnt;
    msg = m;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    msg = ~m;                        // registered copy must be used from here on
    if (n == 0) begin
      check({name, "_err"}, int'(err), 1);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_ready_again"}, int'(ready), 1);
      @(posedge clk);
      #1;
      check({name, "_err_drop"}, int'(err), 0);
      repeat (12 * B) @(negedge clk);
      check({name, "_err_pulses"}, err_cnt - r0, 1);
      check({name, "_no_done"}, done_cnt - d0, 0);
      check({name, "_line_idle"}, int'(line), 1);
    end else begin
      check({name, "_busy"}, int'(busy), 1);
      wait_done(name, n);
      @(negedge clk);
      check({name, "_done_drop"}, int'(done), 0);
      check({name, "_busy_drop"}, int'(busy), 0);
      check({name, "_done_pulses"}, done_cnt - d0, 1);
      check({name, "_bytes_seen"}, exp_q.size(), 0);
    end
  endtask

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    repeat (3) @(negedge clk);
    check("rst_tx0", int'(tx0), 1);
    check("rst_ready0", int'(ready0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_done_err0", int'({done0, err0}), 0);
    check("rst_ready1", int'(ready1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(ready0), 1);

    // Running status off
    run_msg("note_on",   24'h903C64, 3, 8'h90, 8'h3C, 8'h64);
    run_msg("prog_chg",  24'hC507AA, 2, 8'hC5, 8'h07, 8'h00);
    run_msg("clock",     24'hF81234, 1, 8'hF8, 8'h00, 8'h00);
    run_msg("bad_stat",  24'h3C6400, 0, 8'h00, 8'h00, 8'h00);
    run_msg("repeat_90", 24'h904064, 3, 8'h90, 8'h40, 8'h64);
    run_msg("hi_data",   24'h80FF81, 3, 8'h80, 8'hFF, 8'h81);
    run_msg("song_sel",  24'hF305EE, 2, 8'hF3, 8'h05, 8'h00);

    // Two queued messages with MSG_VALID held high
    wait_ready("b2b");
    d0 = done_cnt;
    exp_q.push_back(8'hB0); exp_q.push_back(8'h07); exp_q.push_back(8'h7F);
    exp_q.push_back(8'hE1); exp_q.push_back(8'h00); exp_q.push_back(8'h40);
    msg = 24'hB0077F;
    valid = 1'b1;
    @(posedge clk);
    #1;
    msg = 24'hE10040;
    wait_done("b2b_first", 3);
    check("b2b_ready_with_done", int'(ready), 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    msg = 24'h1EFFBF;
    check("b2b_second_busy", int'(busy), 1);
    wait_done("b2b_second", 3);
    @(negedge clk);
    check("b2b_done_pulses", done_cnt - d0, 2);
    check("b2b_bytes_seen", exp_q.size(), 0);

    // Reset during data bit 3 of the second byte
    wait_ready("rst_mid");
    d0 = done_cnt;
    exp_q.push_back(8'h9A);
    msg = 24'h9A1122;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (14 * B + B / 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_async", int'(tx0), 1);
    check("rst_mid_busy", int'(busy0), 0);
    check("rst_mid_ready", int'(ready0), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * B) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_first_byte", exp_q.size(), 0);
    run_msg("post_rst", 24'h9A1122, 3, 8'h9A, 8'h11, 8'h22);

    // Running status on
    sel = 1'b1;
    @(negedge clk);
    run_msg("rs_first",  24'h903C64, 3, 8'h90, 8'h3C, 8'h64);
    run_msg("rs_repeat", 24'h904064, 2, 8'h40, 8'h64, 8'h00);
    run_msg("rs_rt",     24'hF80000, 1, 8'hF8, 8'h00, 8'h00);
    run_msg("rs_kept",   24'h904364, 2, 8'h43, 8'h64, 8'h00);
    run_msg("rs_sys",    24'hF20000, 3, 8'hF2, 8'h00, 8'h00);
    run_msg("rs_resend", 24'h903C00, 3, 8'h90, 8'h3C, 8'h00);

    repeat (2 * B) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
